// File: rtl/issue_pkg.sv
// Shared types and field constants for the issue scheduler.
package issue_pkg;

    // FSM encoding kept as plain constants for legacy tool flows.
    typedef logic [1:0] state_t;
    localparam state_t StRun     = 2'd0;
    localparam state_t StDrain   = 2'd1;
    localparam state_t StCsrWait = 2'd2;

    // One-hot execution unit select; bit order matches the strobe outputs.
    typedef enum logic [5:0] {
        UnitNone   = 6'b000000,
        UnitExec   = 6'b000001,
        UnitLsu    = 6'b000010,
        UnitBranch = 6'b000100,
        UnitMul    = 6'b001000,
        UnitDiv    = 6'b010000,
        UnitCsr    = 6'b100000
    } unit_e;

    localparam int unsigned RS1_LSB  = 15;
    localparam int unsigned RS2_LSB  = 20;
    localparam int unsigned RD_LSB   = 7;
    localparam int unsigned LOAD_BIT = 5;

    function automatic logic [4:0] reg_field(input logic [31:0] instr, input int unsigned lsb);
        return instr[lsb +: 5];
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch/decode/issue/unit-feedback bundle; names are from the scheduler's view.
interface issue_scheduler_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_accept_o;
    logic        dec_exec_i;
    logic        dec_lsu_i;
    logic        dec_branch_i;
    logic        dec_mul_i;
    logic        dec_div_i;
    logic        dec_csr_i;
    logic        dec_rd_valid_i;
    logic        issue_exec_o;
    logic        issue_lsu_o;
    logic        issue_branch_o;
    logic        issue_mul_o;
    logic        issue_div_o;
    logic        issue_csr_o;
    logic [31:0] issue_opcode_o;
    logic [31:0] issue_pc_o;
    logic [4:0]  issue_rd_o;
    logic        lsu_accept_i;
    logic        lsu_wb_valid_i;
    logic [4:0]  lsu_wb_rd_i;
    logic        div_wb_valid_i;
    logic        csr_done_i;
    logic        flush_i;

    // Fetch, decoder and execution units drive this side.
    modport master (
        output fetch_valid_i, fetch_instr_i, fetch_pc_i,
        output dec_exec_i, dec_lsu_i, dec_branch_i, dec_mul_i, dec_div_i, dec_csr_i,
        output dec_rd_valid_i, lsu_accept_i, lsu_wb_valid_i, lsu_wb_rd_i,
        output div_wb_valid_i, csr_done_i, flush_i,
        input  fetch_accept_o, issue_exec_o, issue_lsu_o, issue_branch_o, issue_mul_o,
        input  issue_div_o, issue_csr_o, issue_opcode_o, issue_pc_o, issue_rd_o
    );

    // The scheduler itself.
    modport slave (
        input  fetch_valid_i, fetch_instr_i, fetch_pc_i,
        input  dec_exec_i, dec_lsu_i, dec_branch_i, dec_mul_i, dec_div_i, dec_csr_i,
        input  dec_rd_valid_i, lsu_accept_i, lsu_wb_valid_i, lsu_wb_rd_i,
        input  div_wb_valid_i, csr_done_i, flush_i,
        output fetch_accept_o, issue_exec_o, issue_lsu_o, issue_branch_o, issue_mul_o,
        output issue_div_o, issue_csr_o, issue_opcode_o, issue_pc_o, issue_rd_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: load/div/mul destination tracking and hazard query.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       load_set_i,
    input  logic       mul_set_i,
    input  logic       div_set_i,
    input  logic       rd_valid_i,
    input  logic       lsu_wb_valid_i,
    input  logic [4:0] lsu_wb_rd_i,
    input  logic       div_wb_valid_i,
    output logic       hazard_o,
    output logic       div_busy_o,
    output logic       empty_o
);
    // A mul result lands MUL_LATENCY cycles after accept; the pending bit must be
    // gone by then, so the pipe is one stage shorter. Latency 1 needs no tracking.
    localparam bit          MulTracked = (MUL_LATENCY > 1);
    localparam int unsigned PipeDepth  = MulTracked ? MUL_LATENCY - 1 : 1;

    logic [31:0]          pend_q, pend_d, set_vec, clr_vec;
    logic [PipeDepth-1:0] mvalid_q, mvalid_d, mwr_q, mwr_d;
    logic [4:0]           mrd_q [PipeDepth];
    logic [4:0]           mrd_d [PipeDepth];
    logic                 div_busy_q, div_busy_d, div_wr_q, div_wr_d;
    logic [4:0]           div_rd_q, div_rd_d;
    logic                 wr_en;

    assign wr_en = rd_valid_i & (rd_i != 5'd0);

    // Mul shift pipe: entry enters at stage 0 and clears its rd on leaving the last stage.
    always_comb begin
        mvalid_d[0] = mul_set_i & MulTracked;
        mwr_d[0]    = mul_set_i & MulTracked & wr_en;
        mrd_d[0]    = rd_i;
        for (int i = 1; i < PipeDepth; i++) begin
            mvalid_d[i] = mvalid_q[i-1];
            mwr_d[i]    = mwr_q[i-1];
            mrd_d[i]    = mrd_q[i-1];
        end
    end

    // Pending bits: clears from writebacks and mul pipe exit, set wins on collision.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lsu_wb_valid_i) clr_vec[lsu_wb_rd_i] = 1'b1;
        if (div_wb_valid_i && div_wr_q) clr_vec[div_rd_q] = 1'b1;
        if (mvalid_q[PipeDepth-1] && mwr_q[PipeDepth-1]) clr_vec[mrd_q[PipeDepth-1]] = 1'b1;
        if (wr_en && (load_set_i || div_set_i || (mul_set_i && MulTracked))) set_vec[rd_i] = 1'b1;
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    // Single outstanding divide: remember its rd for the writeback clear.
    always_comb begin
        div_busy_d = div_busy_q;
        div_wr_d   = div_wr_q;
        div_rd_d   = div_rd_q;
        if (div_set_i) begin
            div_busy_d = 1'b1;
            div_wr_d   = wr_en;
            div_rd_d   = rd_i;
        end else if (div_wb_valid_i) begin
            div_busy_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= '0;
            mvalid_q   <= '0;
            mwr_q      <= '0;
            div_busy_q <= 1'b0;
            div_wr_q   <= 1'b0;
            div_rd_q   <= 5'd0;
            for (int i = 0; i < PipeDepth; i++) mrd_q[i] <= 5'd0;
        end else begin
            pend_q     <= pend_d;
            mvalid_q   <= mvalid_d;
            mwr_q      <= mwr_d;
            div_busy_q <= div_busy_d;
            div_wr_q   <= div_wr_d;
            div_rd_q   <= div_rd_d;
            for (int i = 0; i < PipeDepth; i++) mrd_q[i] <= mrd_d[i];
        end
    end

    assign hazard_o   = pend_q[rs1_i] | pend_q[rs2_i] | pend_q[rd_i];
    assign div_busy_o = div_busy_q;
    assign empty_o    = (pend_q == 32'd0) & ~div_busy_q & (mvalid_q == '0);

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue in-order scheduler: hazard/structural stalls, CSR serialization, unit routing.
module issue_scheduler #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    issue_scheduler_if.slave  bus
);
    import issue_pkg::*;

    state_t      state_q, state_d;
    unit_e       unit, issue_q, issue_d;
    logic [31:0] opcode_q, opcode_d, pc_q, pc_d;
    logic [4:0]  rd_q, rd_d, rs1, rs2, rd;
    logic [5:0]  issue_bits;
    logic        accept, hazard, div_busy, sb_empty, lsu_hold, struct_stall, csr_block;

    assign rs1 = reg_field(bus.fetch_instr_i, RS1_LSB);
    assign rs2 = reg_field(bus.fetch_instr_i, RS2_LSB);
    assign rd  = reg_field(bus.fetch_instr_i, RD_LSB);

    // Decoder flags should be one-hot; a fixed priority guarantees a single strobe anyway.
    always_comb begin
        unit = UnitNone;
        if (bus.dec_csr_i)         unit = UnitCsr;
        else if (bus.dec_div_i)    unit = UnitDiv;
        else if (bus.dec_mul_i)    unit = UnitMul;
        else if (bus.dec_branch_i) unit = UnitBranch;
        else if (bus.dec_lsu_i)    unit = UnitLsu;
        else if (bus.dec_exec_i)   unit = UnitExec;
    end

    assign lsu_hold     = (issue_q == UnitLsu) & ~bus.lsu_accept_i;
    assign struct_stall = ((unit == UnitDiv) & div_busy) | lsu_hold;
    assign csr_block    = (unit == UnitCsr) & ~sb_empty;
    assign accept       = ~rst_i & bus.fetch_valid_i & (state_q == StRun) & ~hazard
                        & ~struct_stall & ~csr_block & ~bus.flush_i;

    issue_scoreboard #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .rd_i           (rd),
        .load_set_i     (accept & (unit == UnitLsu) & ~bus.fetch_instr_i[LOAD_BIT]),
        .mul_set_i      (accept & (unit == UnitMul)),
        .div_set_i      (accept & (unit == UnitDiv)),
        .rd_valid_i     (bus.dec_rd_valid_i),
        .lsu_wb_valid_i (bus.lsu_wb_valid_i),
        .lsu_wb_rd_i    (bus.lsu_wb_rd_i),
        .div_wb_valid_i (bus.div_wb_valid_i),
        .hazard_o       (hazard),
        .div_busy_o     (div_busy),
        .empty_o        (sb_empty)
    );

    // CSR serialization: drain everything in flight, issue, then wait for completion.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept && unit == UnitCsr) state_d = StCsrWait;
                    else if (bus.fetch_valid_i && unit == UnitCsr && !sb_empty) state_d = StDrain;
                end
                StDrain:   if (sb_empty) state_d = StRun;
                StCsrWait: if (bus.csr_done_i) state_d = StRun;
                default:   state_d = StRun;
            endcase
        end
    end

    // Issue register: load on accept, keep an un-taken LSU op, otherwise strobe for one cycle.
    always_comb begin
        issue_d  = issue_q;
        opcode_d = opcode_q;
        pc_d     = pc_q;
        rd_d     = rd_q;
        if (bus.flush_i) begin
            issue_d = UnitNone;
        end else if (accept) begin
            issue_d  = unit;
            opcode_d = bus.fetch_instr_i;
            pc_d     = bus.fetch_pc_i;
            rd_d     = rd;
        end else if (!lsu_hold) begin
            issue_d = UnitNone;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StRun;
            issue_q  <= UnitNone;
            opcode_q <= 32'd0;
            pc_q     <= 32'd0;
            rd_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            opcode_q <= opcode_d;
            pc_q     <= pc_d;
            rd_q     <= rd_d;
        end
    end

    assign issue_bits         = issue_q;
    assign bus.issue_exec_o   = issue_bits[0];
    assign bus.issue_lsu_o    = issue_bits[1];
    assign bus.issue_branch_o = issue_bits[2];
    assign bus.issue_mul_o    = issue_bits[3];
    assign bus.issue_div_o    = issue_bits[4];
    assign bus.issue_csr_o    = issue_bits[5];
    assign bus.issue_opcode_o = opcode_q;
    assign bus.issue_pc_o     = pc_q;
    assign bus.issue_rd_o     = rd_q;
    assign bus.fetch_accept_o = accept;

endmodule
